pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline register for the RV32 core; replaces per-stage stall/flush regs.
//  Carries {pc, instr, meta} between stages with valid/ready handshake, flush, NOP bubbles.
//  Holds 1 entry (combinational ready) or 2 entries (registered ready, skid) per PIPE_SKID_EN.
// PARAMETERS
//  PC_W      32              pc field width
//  INSTR_W   32              instruction field width
//  META_W    8               sideband bits (predicted-taken, exception flags, ...)
//  NOP_INSTR 32'h0000_0013   instr value driven on bubbles (ADDI x0,x0,0)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-high
//  flush      in   1        sync clear of all held entries (branch taken / trap)
//  in_valid   in   1        upstream beat valid
//  in_ready   out  1        stage can accept beat
//  in_pc      in   PC_W     upstream pc
//  in_instr   in   INSTR_W  upstream instruction
//  in_meta    in   META_W   upstream sideband
//  out_valid  out  1        downstream beat valid
//  out_ready  in   1        downstream accepts (deasserted = stall)
//  out_pc     out  PC_W     head pc
//  out_instr  out  INSTR_W  head instruction
//  out_meta   out  META_W   head sideband
//  occ        out  2        entries held (0..1, or 0..2 with skid)
// BEHAVIOUR
//  - Reset (async): out_valid=0, out_pc=0, out_instr=NOP_INSTR, out_meta=0, occ=0, in_ready=1.
//  - Accept = in_valid&&in_ready; deliver = out_valid&&out_ready. Beats stay in order.
//  - Latency: accepted beat appears on out_* next cycle when stage empty.
//  - While out_valid&&!out_ready: out_* stable, no beat lost or duplicated.
//  - out_valid=0 => out_pc=0, out_instr=NOP_INSTR, out_meta=0 (bubble is a legal NOP).
//  - flush (sync; below rst only): next cycle occ=0, out_valid=0, bubble payload;
//    beat accepted in flush cycle discarded; deliver in flush cycle counts as consumed.
//  - in_valid must hold with payload stable until accepted (upstream rule; bench asserts).
//  - occ: +1 on accept, -1 on deliver, unchanged on both; forced 0 by flush.
//  - No over/underflow: accept only if in_ready; deliver only if out_valid.
// CONFIGURATION
//  Macro PIPE_SKID_EN:
//  - defined: 2 entries (main + skid). in_ready is a flop = !skid_valid; no comb path
//    out_ready->in_ready. Accept during out stall fills skid; next deliver moves skid->main
//    same cycle; in_ready returns 1 one cycle after skid drains. Full throughput.
//  - undefined: 1 entry; in_ready = !out_valid || out_ready (comb). occ max 1.
//  - Handshake/ordering/flush/bubble rules identical in both builds.
// STRUCTURE
//  - Package pipe_pkg: NOP_INSTR constant, payload struct typedef pipe_payload_t
//    {pc, instr, meta}, bubble constant PIPE_BUBBLE.
//  - Sub-module pipe_slot: one valid+payload register with load/clear/bubble-on-empty;
//    instantiated once (main) or twice (main+skid). Control logic in this module.
// TESTING
//  1 Reset: rst=1 mid-traffic -> same edge out_valid=0, out_instr=0x13, occ=0, in_ready=1.
//  2 Stream: 8 beats pc=0x0,0x4..0x1C, out_ready=1 -> out 1 cycle later, 1 beat/cycle, in order.
//  3 Stall: out_ready=0 holding pc=0x100 -> out_* stable; skid: 2nd beat 0x104 taken,
//    in_ready=0, occ=2; no skid: in_ready=0, occ=1; release -> 0x100 then 0x104.
//  4 Flush: occ=2, flush=1 with in beat pc=0x200 -> next cycle occ=0, out_valid=0,
//    out_instr=0x13; 0x200 never appears on out.
//  5 Simultaneous: occ=1, accept+deliver same cycle -> occ stays 1, out_pc = new beat.
//  6 Random valid/ready 10k cycles both builds -> scoreboard: order kept, no loss/dup.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline register.
// The default payload layout is {pc, instr, meta}; a bubble is the canonical NOP with zero pc/meta.
package pipe_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int META_W_DEF  = 8;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
        logic [META_W_DEF-1:0]  meta;
    } pipe_payload_t;

    localparam pipe_payload_t PIPE_BUBBLE = '{pc: '0, instr: NOP_INSTR, meta: '0};

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload register. The payload register itself holds the bubble whenever the slot is empty,
// so the outputs come straight from flops.
module pipe_slot #(
    parameter int           W      = 72,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         unload,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (unload) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register carrying {pc, instr, meta} with valid/ready, flush and NOP bubbles.
// Define PIPE_SKID_EN for the 2-entry build (registered in_ready); otherwise 1 entry with comb in_ready.
module pipe_stage_elastic #(
    parameter int                 PC_W      = pipe_pkg::PC_W_DEF,
    parameter int                 INSTR_W   = pipe_pkg::INSTR_W_DEF,
    parameter int                 META_W    = pipe_pkg::META_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(pipe_pkg::NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [META_W-1:0]  in_meta,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [META_W-1:0]  out_meta,
    output logic [1:0]         occ
);

    localparam int           W      = PC_W + INSTR_W + META_W;
    localparam logic [W-1:0] BUBBLE = {{PC_W{1'b0}}, NOP_INSTR, {META_W{1'b0}}};

    logic [W-1:0] in_word;
    logic [W-1:0] main_d;
    logic [W-1:0] main_q;
    logic         main_valid;
    logic         main_load;
    logic         main_unload;
    logic         accept;
    logic         deliver;

    assign in_word   = {in_pc, in_instr, in_meta};
    assign accept    = in_valid && in_ready;
    assign deliver   = main_valid && out_ready;
    assign out_valid = main_valid;
    assign {out_pc, out_instr, out_meta} = main_q;

`ifdef PIPE_SKID_EN
    logic [W-1:0] skid_q;
    logic         skid_valid;
    logic         main_take;
    logic         skid_load;
    logic         skid_unload;

    // Ready depends only on the skid flop, so out_ready never reaches in_ready combinationally.
    assign in_ready    = !skid_valid;
    assign main_take   = !main_valid || deliver;
    assign main_load   = main_take && (skid_valid || accept);
    assign main_d      = skid_valid ? skid_q : in_word;
    assign main_unload = deliver;
    assign skid_load   = accept && main_valid && !deliver;
    assign skid_unload = skid_valid && deliver;
    assign occ         = {1'b0, main_valid} + {1'b0, skid_valid};

    pipe_slot #(.W(W), .BUBBLE(BUBBLE)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (flush),
        .d      (in_word),
        .valid  (skid_valid),
        .q      (skid_q)
    );
`else
    assign in_ready    = !main_valid || out_ready;
    assign main_load   = accept;
    assign main_d      = in_word;
    assign main_unload = deliver;
    assign occ         = {1'b0, main_valid};
`endif

    pipe_slot #(.W(W), .BUBBLE(BUBBLE)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .unload (main_unload),
        .clear  (flush),
        .d      (main_d),
        .valid  (main_valid),
        .q      (main_q)
    );

endmodule
